// File: rtl/mem_arb_defs.sv
// Shared definitions for the memory port arbiter: FSM encoding, arbitration
// mode constants and index-width helper.
package mem_arb_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam int WD_W      = 32;

    // A single requester still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Grant selection: scans the request vector starting at i_start (round-robin)
// or at index 0 (fixed priority) and returns the first asserted index.
module arb_pick
    import mem_arb_defs::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_start,
    input  logic             i_mode,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    int               w_base;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        w_base  = i_mode ? int'(i_start) : 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = IDX_W'((w_base + k) % N_REQ);
            if (!o_valid && i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between N_REQ pipeline requesters with an
// IDLE -> BUSY -> RESP access FSM, optional round-robin and a BUSY watchdog.
module mem_port_arbiter
    import mem_arb_defs::*;
#(
    parameter int N_REQ    = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 0
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [N_REQ-1:0]         Req_Valid,
    input  logic [N_REQ-1:0]         Req_Write,
    input  logic [N_REQ*ADDR_W-1:0]  Req_Addr,
    input  logic [N_REQ*DATA_W-1:0]  Req_WData,
    output logic [N_REQ-1:0]         Req_Done,
    output logic [N_REQ-1:0]         Req_Stall,
    output logic [DATA_W-1:0]        Rsp_Data,
    output logic                     Rsp_Err,
    output logic [ADDR_W-1:0]        Mem_Address,
    output logic                     Mem_WriteEnable,
    output logic [DATA_W-1:0]        Mem_DataOut,
    input  logic [DATA_W-1:0]        Mem_DataIn,
    input  logic                     Mem_Ready,
    output logic [1:0]               Dbg_State
);

    localparam int IDX_W = idx_width(N_REQ);

    arb_state_t        r_state, w_next;
    logic [IDX_W-1:0]  r_grant, r_last, w_start, w_pick_idx;
    logic              w_pick_valid, w_timeout;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic              r_write, r_err;
    logic [WD_W-1:0]   r_wd;
    logic [N_REQ-1:0]  r_done;

    logic [ADDR_W-1:0] w_addr  [N_REQ];
    logic [DATA_W-1:0] w_wdata [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_addr[g]  = Req_Addr[g*ADDR_W +: ADDR_W];
        assign w_wdata[g] = Req_WData[g*DATA_W +: DATA_W];
    end

    always_comb begin
        if (r_last == IDX_W'(N_REQ - 1)) w_start = '0;
        else                             w_start = r_last + 1'b1;
    end

    arb_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .i_req   (Req_Valid),
        .i_start (w_start),
        .i_mode  (ARB_MODE == ARB_RR),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    always_ff @(posedge Clock) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Mem_Ready is tested first so a completion on the timeout edge wins.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: if (w_pick_valid) w_next = ST_BUSY;
            ST_BUSY: begin
                if (Mem_Ready) begin
                    w_next = ST_RESP;
                end else if ((TIMEOUT > 0) && (r_wd == WD_W'(TIMEOUT - 1))) begin
                    w_next    = ST_RESP;
                    w_timeout = 1'b1;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_grant <= '0;
            r_last  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_wd    <= '0;
            r_done  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick_idx;
                        r_last  <= w_pick_idx;
                        r_addr  <= w_addr[w_pick_idx];
                        r_wdata <= w_wdata[w_pick_idx];
                        r_write <= Req_Write[w_pick_idx];
                        r_wd    <= '0;
                    end
                end
                ST_BUSY: begin
                    if (Mem_Ready) begin
                        r_rdata <= r_write ? '0 : Mem_DataIn;
                        r_err   <= 1'b0;
                        r_done  <= N_REQ'(1) << r_grant;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_done  <= N_REQ'(1) << r_grant;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Mem_Address     = (r_state == ST_BUSY) ? r_addr  : '0;
    assign Mem_DataOut     = (r_state == ST_BUSY) ? r_wdata : '0;
    assign Mem_WriteEnable = (r_state == ST_BUSY) && r_write;
    assign Req_Done        = r_done;
    assign Req_Stall       = Req_Valid & ~r_done;
    assign Rsp_Data        = r_rdata;
    assign Rsp_Err         = r_err;
    assign Dbg_State       = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 is fixed priority with TIMEOUT=4,
// instance 1 is round-robin with the watchdog disabled.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst        [2];
  logic [1:0]  req_valid  [2];
  logic [1:0]  req_write  [2];
  logic [63:0] req_addr   [2];
  logic [63:0] req_wdata  [2];
  logic [31:0] mem_din    [2];
  logic        mem_ready  [2];
  logic [1:0]  done       [2];
  logic [1:0]  stall      [2];
  logic [31:0] rsp_data   [2];
  logic        rsp_err    [2];
  logic [31:0] mem_addr   [2];
  logic        mem_we     [2];
  logic [31:0] mem_dout   [2];
  logic [1:0]  dbg        [2];

  int n_checks = 0;
  int n_err    = 0;
  int rr_last  = 0;
  logic [31:0] exp_q[$];

  mem_port_arbiter #(.N_REQ(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT(4)) u_fix (
    .Clock(clk), .Reset(rst[0]), .Req_Valid(req_valid[0]), .Req_Write(req_write[0]),
    .Req_Addr(req_addr[0]), .Req_WData(req_wdata[0]), .Req_Done(done[0]), .Req_Stall(stall[0]),
    .Rsp_Data(rsp_data[0]), .Rsp_Err(rsp_err[0]), .Mem_Address(mem_addr[0]),
    .Mem_WriteEnable(mem_we[0]), .Mem_DataOut(mem_dout[0]), .Mem_DataIn(mem_din[0]),
    .Mem_Ready(mem_ready[0]), .Dbg_State(dbg[0])
  );

  mem_port_arbiter #(.N_REQ(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT(0)) u_rr (
    .Clock(clk), .Reset(rst[1]), .Req_Valid(req_valid[1]), .Req_Write(req_write[1]),
    .Req_Addr(req_addr[1]), .Req_WData(req_wdata[1]), .Req_Done(done[1]), .Req_Stall(stall[1]),
    .Rsp_Data(rsp_data[1]), .Rsp_Err(rsp_err[1]), .Mem_Address(mem_addr[1]),
    .Mem_WriteEnable(mem_we[1]), .Mem_DataOut(mem_dout[1]), .Mem_DataIn(mem_din[1]),
    .Mem_Ready(mem_ready[1]), .Dbg_State(dbg[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  vec;
    logic [1:0]  wr;
    logic [31:0] a0, a1, d0, d1, din;
    int          waits;
    int          e_grant;
    logic [31:0] e_addr, e_dout, e_rdata;
    logic        e_we, e_err;
    int          e_lat;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one access from an IDLE cycle through its Req_Done pulse
  task automatic run_txn(input string tag, input int inst, input logic [1:0] vec, input logic [1:0] wr,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] d0,
                         input logic [31:0] d1, input logic [31:0] din, input int waits,
                         input logic perturb, input int e_grant, input logic [31:0] e_addr,
                         input logic [31:0] e_dout, input logic e_we, input logic [31:0] e_rdata,
                         input logic e_err, input int e_lat);
    int          cyc, lat, grant, stall_bad;
    logic        stable, idle_resp, o_we, o_err;
    logic [31:0] o_addr, o_dout, o_rdata;
    req_valid[inst] = vec;
    req_write[inst] = wr;
    req_addr[inst]  = {a1, a0};
    req_wdata[inst] = {d1, d0};
    mem_din[inst]   = din;
    mem_ready[inst] = 1'b0;
    #1;
    cyc = 1; lat = -1; grant = -1; stall_bad = 0; stable = 1'b1; idle_resp = 1'b0;
    o_addr = '0; o_dout = '0; o_we = 1'b0; o_err = 1'b0; o_rdata = '0;
    if (stall[inst] !== vec) stall_bad++;
    while (cyc < 20 && lat < 0) begin
      tick();
      cyc++;
      if (done[inst] != 2'b00) begin
        lat       = cyc;
        grant     = (done[inst] == 2'b01) ? 0 : (done[inst] == 2'b10) ? 1 : 9;
        o_rdata   = rsp_data[inst];
        o_err     = rsp_err[inst];
        idle_resp = (mem_addr[inst] == 0) && (mem_dout[inst] == 0) && !mem_we[inst];
        if (stall[inst] !== (req_valid[inst] & ~done[inst])) stall_bad++;
      end else begin
        if (cyc == 2) begin
          o_addr = mem_addr[inst]; o_dout = mem_dout[inst]; o_we = mem_we[inst];
        end else if (mem_addr[inst] !== o_addr || mem_dout[inst] !== o_dout || mem_we[inst] !== o_we) begin
          stable = 1'b0;
        end
        if (stall[inst] !== req_valid[inst]) stall_bad++;
        if (perturb) begin
          req_valid[inst] = 2'($urandom_range(0, 3));
          req_addr[inst]  = {$urandom, $urandom};
          req_wdata[inst] = {$urandom, $urandom};
        end
        mem_ready[inst] = ((cyc - 2) >= waits);
      end
    end
    check({tag, "_latency"}, lat, e_lat);
    check({tag, "_grant"}, grant, e_grant);
    check({tag, "_addr"}, o_addr, e_addr);
    check({tag, "_dout"}, o_dout, e_dout);
    check({tag, "_we"}, {31'd0, o_we}, {31'd0, e_we});
    check({tag, "_stable"}, {31'd0, stable}, 32'd1);
    check({tag, "_rdata"}, o_rdata, e_rdata);
    check({tag, "_err"}, {31'd0, o_err}, {31'd0, e_err});
    check({tag, "_mem_idle_resp"}, {31'd0, idle_resp}, 32'd1);
    check({tag, "_stall"}, stall_bad, 0);
    req_valid[inst] = 2'b00;
    mem_ready[inst] = 1'b0;
    tick();
  endtask

  // reference model: winner and outcome from the arbitration/timeout rules
  function automatic int model_winner(input int inst, input logic [1:0] vec);
    if (inst == 0) return vec[0] ? 0 : (vec[1] ? 1 : -1);
    for (int k = 1; k <= 2; k++) begin
      if (vec[(rr_last + k) % 2]) return (rr_last + k) % 2;
    end
    return -1;
  endfunction

  task automatic random_txn(input int inst, input int n);
    logic [1:0]  vec, wr;
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [31:0] din, e_rdata;
    int          waits, w, tmo, e_lat;
    logic        e_err;
    vec   = 2'($urandom_range(1, 3));
    wr    = 2'($urandom_range(0, 3));
    a[0]  = $urandom; a[1] = $urandom;
    d[0]  = $urandom; d[1] = $urandom;
    din   = $urandom;
    waits = $urandom_range(0, 6);
    tmo   = (inst == 0) ? 4 : 0;
    w     = model_winner(inst, vec);
    if (tmo > 0 && waits >= tmo) begin
      e_lat = 2 + tmo; e_err = 1'b1; e_rdata = '0;
    end else begin
      e_lat = waits + 3; e_err = 1'b0; e_rdata = wr[w] ? 32'd0 : din;
    end
    if (inst == 1) rr_last = w;
    run_txn($sformatf("rnd%0d_%0d", inst, n), inst, vec, wr, a[0], a[1], d[0], d[1], din, waits,
            1'b1, w, a[w], d[w], wr[w], e_rdata, e_err, e_lat);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req_valid[i] = '0; req_write[i] = '0; req_addr[i] = '0;
      req_wdata[i] = '0; mem_din[i] = '0; mem_ready[i] = 1'b0;
    end
    //                 vec    wr     a0        a1        d0        d1        din           wt gr addr      dout      rdata         we    err   lat
    tbl[0] = '{2'b01, 2'b00, 32'h100, 32'h0,   32'h0,    32'h0,    32'h11112222, 0, 0, 32'h100, 32'h0,    32'h11112222, 1'b0, 1'b0, 3};
    tbl[1] = '{2'b10, 2'b10, 32'h0,   32'h200, 32'h0,    32'hA5A5, 32'h77777777, 1, 1, 32'h200, 32'hA5A5, 32'h0,        1'b1, 1'b0, 4};
    tbl[2] = '{2'b11, 2'b10, 32'h300, 32'h310, 32'h1,    32'h2,    32'hCAFEF00D, 2, 0, 32'h300, 32'h1,    32'hCAFEF00D, 1'b0, 1'b0, 5};
    tbl[3] = '{2'b01, 2'b00, 32'h40,  32'h0,   32'h0,    32'h0,    32'hDEADBEEF, 3, 0, 32'h40,  32'h0,    32'hDEADBEEF, 1'b0, 1'b0, 6};
    tbl[4] = '{2'b10, 2'b00, 32'h0,   32'h44,  32'h0,    32'h9,    32'h12345678, 4, 1, 32'h44,  32'h9,    32'h0,        1'b0, 1'b1, 6};
    tbl[5] = '{2'b01, 2'b01, 32'h48,  32'h0,   32'h3C,   32'h0,    32'h87654321, 50, 0, 32'h48, 32'h3C,   32'h0,        1'b1, 1'b1, 6};
    tbl[6] = '{2'b11, 2'b01, 32'h500, 32'h600, 32'h55,   32'h66,   32'hFFFFFFFF, 0, 0, 32'h500, 32'h55,   32'h0,        1'b1, 1'b0, 3};

    repeat (2) tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_state%0d", i), {30'd0, dbg[i]}, 32'd0);
      check($sformatf("reset_done%0d", i), {30'd0, done[i]}, 32'd0);
      check($sformatf("reset_rdata%0d", i), rsp_data[i], 32'd0);
      check($sformatf("reset_err%0d", i), {31'd0, rsp_err[i]}, 32'd0);
      check($sformatf("reset_mem%0d", i), mem_addr[i] | mem_dout[i] | {31'd0, mem_we[i]}, 32'd0);
      rst[i] = 1'b0;
    end
    tick();

    for (int t = 0; t < 7; t++) begin
      run_txn($sformatf("tbl%0d", t), 0, tbl[t].vec, tbl[t].wr, tbl[t].a0, tbl[t].a1, tbl[t].d0,
              tbl[t].d1, tbl[t].din, tbl[t].waits, 1'b0, tbl[t].e_grant, tbl[t].e_addr,
              tbl[t].e_dout, tbl[t].e_we, tbl[t].e_rdata, tbl[t].e_err, tbl[t].e_lat);
    end

    // fixed-priority collision, back to back
    req_valid[0] = 2'b11; req_write[0] = 2'b00;
    req_addr[0] = {32'h200, 32'h100}; mem_ready[0] = 1'b1;
    #1;
    check("coll_c1_idle_addr", mem_addr[0], 32'h0);
    tick(); check("coll_c2_addr", mem_addr[0], 32'h100);
    tick(); check("coll_c3_done", {30'd0, done[0]}, 32'h1);
    req_valid[0] = 2'b10;
    tick(); check("coll_c4_idle_addr", mem_addr[0], 32'h0);
    tick(); check("coll_c5_addr", mem_addr[0], 32'h200);
    tick(); check("coll_c6_done", {30'd0, done[0]}, 32'h2);
    req_valid[0] = 2'b00; mem_ready[0] = 1'b0;
    tick();

    // reset during the second BUSY cycle of a write
    req_valid[0] = 2'b01; req_write[0] = 2'b01;
    req_addr[0] = {32'h0, 32'h80}; req_wdata[0] = {32'h0, 32'h55};
    tick(); check("rstw_c2_we", {31'd0, mem_we[0]}, 32'd1);
    check("rstw_c2_dout", mem_dout[0], 32'h55);
    tick(); rst[0] = 1'b1;
    tick(); rst[0] = 1'b0; req_valid[0] = 2'b00;
    check("rstw_we_after", {31'd0, mem_we[0]}, 32'd0);
    check("rstw_state_idle", {30'd0, dbg[0]}, 32'd0);
    cnt = (done[0] != 0) ? 1 : 0;
    repeat (5) begin
      tick();
      if (done[0] != 0) cnt++;
    end
    check("rstw_no_done", cnt, 0);

    // round-robin: both held high, grants alternate starting at 1
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    req_valid[1] = 2'b11; req_write[1] = 2'b00; mem_ready[1] = 1'b1;
    for (int c = 2; c <= 12; c++) begin
      tick();
      if (done[1] != 0) begin
        if (exp_q.size() == 0) check("rr_extra_done", {30'd0, done[1]}, 32'd0);
        else check($sformatf("rr_grant_c%0d", c), (done[1] == 2'b10) ? 32'd1 : (done[1] == 2'b01) ? 32'd0 : 32'd9, exp_q.pop_front());
      end
    end
    check("rr_all_grants", exp_q.size(), 0);
    req_valid[1] = 2'b00; mem_ready[1] = 1'b0;
    rr_last = 0;
    tick();

    for (int n = 0; n < 30; n++) random_txn(0, n);
    for (int n = 0; n < 30; n++) random_txn(1, n);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
